// File: rtl/alu_sequencer_pkg.sv
// Shared ALU opcode encoding, datapath width and the flag-update decode used by
// both the ALU and the sequencer.
package alu_sequencer_pkg;

  localparam int unsigned WORD_SIZE = 8;

  typedef enum logic [3:0] {
    OpAdd = 4'h0,
    OpAdc = 4'h1,
    OpSub = 4'h2,
    OpAnd = 4'h3,
    OpOr  = 4'h4,
    OpXor = 4'h5,
    OpCmp = 4'h6,
    OpInc = 4'h7,
    OpDec = 4'h8,
    OpShr = 4'h9,
    OpShl = 4'hA
  } opcode_t;

  // One bit per opcode value; undefined encodings leave every flag untouched.
  localparam logic [15:0] FLAG_UPDATE_C  = 16'h0007;  // ADD, ADC, SUB
  localparam logic [15:0] FLAG_UPDATE_ZN = 16'h007F;  // ADD..CMP

  function automatic logic updates_c(opcode_t op);
    return FLAG_UPDATE_C[op];
  endfunction

  function automatic logic updates_zn(opcode_t op);
    return FLAG_UPDATE_ZN[op];
  endfunction

endpackage

// File: rtl/alu_flags_reg.sv
// Architectural C/Z/N flags register with an independent write enable per flag.
module alu_flags_reg (
  input  logic clk,
  input  logic rst,
  input  logic we_c,
  input  logic we_z,
  input  logic we_n,
  input  logic c_next,
  input  logic z_next,
  input  logic n_next,
  output logic flag_c,
  output logic flag_z,
  output logic flag_n
);

  logic c_q, z_q, n_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q <= 1'b0;
      z_q <= 1'b0;
      n_q <= 1'b0;
    end else begin
      if (we_c) c_q <= c_next;
      if (we_z) z_q <= z_next;
      if (we_n) n_q <= n_next;
    end
  end

  assign flag_c = c_q;
  assign flag_z = z_q;
  assign flag_n = n_q;

endmodule

// File: rtl/alu_sequencer.sv
// Initiator for the combinational ALU: registers one request, lets the ALU settle for
// a full cycle, captures result and flags, and holds them until the consumer takes them.
module alu_sequencer #(
  parameter int unsigned WORD_SIZE = alu_sequencer_pkg::WORD_SIZE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  alu_sequencer_pkg::opcode_t req_opcode,
  input  logic [WORD_SIZE-1:0]      req_a,
  input  logic [WORD_SIZE-1:0]      req_b,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [WORD_SIZE-1:0]      resp_result,
  output logic                      flags_c,
  output logic                      flags_z,
  output logic                      flags_n,
  output alu_sequencer_pkg::opcode_t alu_opcode,
  output logic [WORD_SIZE-1:0]      alu_a,
  output logic [WORD_SIZE-1:0]      alu_b,
  output logic                      alu_carry_in,
  input  logic [WORD_SIZE-1:0]      alu_out,
  input  logic                      alu_flag_c,
  input  logic                      alu_flag_z,
  input  logic                      alu_flag_n
);

  import alu_sequencer_pkg::*;

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_t;

  state_t               state_q, state_d;
  opcode_t              op_q;
  logic [WORD_SIZE-1:0] a_q, b_q;
  logic [WORD_SIZE-1:0] result_q;
  logic                 accept;
  logic                 capture;
  logic                 we_c, we_zn;

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) state_d = StExec;
      end
      StExec: begin
        state_d = StDone;
      end
      StDone: begin
        req_ready = resp_ready;
        if (resp_ready) state_d = req_valid ? StExec : StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign accept  = req_valid & req_ready;
  assign capture = (state_q == StExec);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= OpAdd;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      // Operands move only on accept so the ALU inputs never glitch mid-operation.
      if (accept) begin
        op_q <= req_opcode;
        a_q  <= req_a;
        b_q  <= req_b;
      end
      if (capture) result_q <= alu_out;
    end
  end

  assign we_c  = capture & updates_c(op_q);
  assign we_zn = capture & updates_zn(op_q);

  alu_flags_reg u_flags (
    .clk    (clk),
    .rst    (rst),
    .we_c   (we_c),
    .we_z   (we_zn),
    .we_n   (we_zn),
    .c_next (alu_flag_c),
    .z_next (alu_flag_z),
    .n_next (alu_flag_n),
    .flag_c (flags_c),
    .flag_z (flags_z),
    .flag_n (flags_n)
  );

  assign resp_valid   = (state_q == StDone);
  assign resp_result  = result_q;
  assign alu_opcode   = op_q;
  assign alu_a        = a_q;
  assign alu_b        = b_q;
  // ADC sees the flag as registered before the operation started.
  assign alu_carry_in = flags_c;

endmodule
